// File: rtl/key_sched_ctrl.sv
// Key-schedule sequencer: drives one single-round expansion unit per round and
// keeps every round key in a local register file for indexed read-back.
module key_sched_ctrl #(
   parameter int unsigned RK_W   = 128,
   parameter int unsigned NUM_RK = 15
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start_valid,
   output logic              start_ready,
   input  logic [2*RK_W-1:0] key_in,
   input  logic              key_len,
   output logic              busy,
   output logic              keys_valid,
   input  logic [3:0]        rd_addr,
   output logic [RK_W-1:0]   rd_key,
   output logic [RK_W-1:0]   gk_key,
   output logic [RK_W-1:0]   gk_prev_key,
   output logic              gk_keylen,
   output logic              gk_flip,
   output logic [3:0]        gk_rnum,
   output logic              gk_valid_in,
   input  logic              gk_valid_out,
   input  logic [RK_W-1:0]   gk_out_key
);

   localparam int unsigned NUM_RK_128 = 11;

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

   state_t          state_q, state_d;
   logic            len_q, len_d;
   logic [3:0]      idx_q, idx_d;
   logic [RK_W-1:0] cur_q, cur_d;
   logic [RK_W-1:0] prev_q, prev_d;
   logic [RK_W-1:0] rk_q [NUM_RK];
   logic [RK_W-1:0] rk_d [NUM_RK];
   logic [RK_W-1:0] rd_key_q, rd_key_d;
   logic [RK_W-1:0] gk_key_q, gk_key_d;
   logic [RK_W-1:0] gk_prev_q, gk_prev_d;
   logic            gk_keylen_q, gk_keylen_d;
   logic            gk_flip_q, gk_flip_d;
   logic [3:0]      gk_rnum_q, gk_rnum_d;

   logic            accept;
   logic            round_done;
   logic            iss_flip;
   logic [3:0]      iss_rnum;
   logic [3:0]      last_idx;
   logic            rd_in_range;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE, DONE: if (accept) state_d = ISSUE;
         ISSUE:      state_d = WAIT;
         WAIT:       if (gk_valid_out) state_d = (idx_q == last_idx) ? DONE : ISSUE;
         default:    state_d = IDLE;
      endcase
   end

   always_comb begin
      start_ready = (state_q == IDLE) || (state_q == DONE);
      busy        = (state_q == ISSUE) || (state_q == WAIT);
      keys_valid  = (state_q == DONE);
      gk_valid_in = (state_q == ISSUE);
      gk_key      = gk_key_d;
      gk_prev_key = gk_prev_d;
      gk_keylen   = gk_keylen_d;
      gk_flip     = gk_flip_d;
      gk_rnum     = gk_rnum_d;
      rd_key      = rd_key_q;
   end

   assign accept     = start_valid && start_ready;
   assign round_done = (state_q == WAIT) && gk_valid_out;
   assign last_idx   = len_q ? 4'(NUM_RK - 1) : 4'(NUM_RK_128 - 1);

   // AES-256 alternates full (even idx) and SubWord-only (odd idx) rounds
   always_comb begin
      iss_flip = 1'b1;
      iss_rnum = idx_q - 4'd1;
      if (len_q) begin
         if (idx_q[0]) begin
            iss_flip = 1'b0;
            iss_rnum = {1'b0, idx_q[3:1]};
         end else begin
            iss_rnum = {1'b0, idx_q[3:1]} - 4'd1;
         end
      end
   end

   always_comb begin
      len_d       = len_q;
      idx_d       = idx_q;
      cur_d       = cur_q;
      prev_d      = prev_q;
      rk_d        = rk_q;
      gk_key_d    = gk_key_q;
      gk_prev_d   = gk_prev_q;
      gk_keylen_d = gk_keylen_q;
      gk_flip_d   = gk_flip_q;
      gk_rnum_d   = gk_rnum_q;

      if (accept) begin
         len_d = key_len;
         if (key_len) begin
            rk_d[0] = key_in[2*RK_W-1:RK_W];
            rk_d[1] = key_in[RK_W-1:0];
            prev_d  = key_in[2*RK_W-1:RK_W];
            cur_d   = key_in[RK_W-1:0];
            idx_d   = 4'd2;
         end else begin
            rk_d[0] = key_in[RK_W-1:0];
            cur_d   = key_in[RK_W-1:0];
            idx_d   = 4'd1;
         end
      end

      // Issue values are live during ISSUE and held afterwards
      if (state_q == ISSUE) begin
         gk_key_d    = cur_q;
         gk_prev_d   = prev_q;
         gk_keylen_d = len_q;
         gk_flip_d   = iss_flip;
         gk_rnum_d   = iss_rnum;
      end

      if (round_done) begin
         rk_d[idx_q] = gk_out_key;
         prev_d      = cur_q;
         cur_d       = gk_out_key;
         if (idx_q != last_idx) idx_d = idx_q + 4'd1;
      end
   end

   always_comb begin
      rd_in_range = len_q ? (rd_addr < 4'(NUM_RK)) : (rd_addr < 4'(NUM_RK_128));
      rd_key_d    = rd_in_range ? rk_q[rd_addr] : '0;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         len_q       <= 1'b0;
         idx_q       <= '0;
         cur_q       <= '0;
         prev_q      <= '0;
         rd_key_q    <= '0;
         gk_key_q    <= '0;
         gk_prev_q   <= '0;
         gk_keylen_q <= 1'b0;
         gk_flip_q   <= 1'b0;
         gk_rnum_q   <= '0;
         for (int unsigned i = 0; i < NUM_RK; i++) rk_q[i] <= '0;
      end else begin
         len_q       <= len_d;
         idx_q       <= idx_d;
         cur_q       <= cur_d;
         prev_q      <= prev_d;
         rd_key_q    <= rd_key_d;
         gk_key_q    <= gk_key_d;
         gk_prev_q   <= gk_prev_d;
         gk_keylen_q <= gk_keylen_d;
         gk_flip_q   <= gk_flip_d;
         gk_rnum_q   <= gk_rnum_d;
         rk_q        <= rk_d;
      end
   end

endmodule

// File: tb/tb_key_sched_ctrl.sv
// Bench for key_sched_ctrl: behavioural expansion unit, FIPS-197 vectors,
// issue-trace and read-back scoreboards.
module tb_key_sched_ctrl;

   localparam logic [127:0] K_C1    = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] C1_RK1  = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;
   localparam logic [127:0] C1_RK10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;
   localparam logic [127:0] K_A1    = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] A1_RK1  = 128'ha0fafe1788542cb123a339392a6c7605;
   localparam logic [127:0] A1_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
   localparam logic [255:0] K_C3    = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
   localparam logic [127:0] C3_RK1  = 128'h101112131415161718191a1b1c1d1e1f;
   localparam logic [127:0] C3_RK2  = 128'ha573c29fa176c498a97fce93a572c09c;
   localparam logic [127:0] C3_RK14 = 128'h24fc79ccbf0979e9371ac23c6d68de36;
   localparam logic [127:0] JUNK    = 128'hdeadbeefcafef00d5555aaaa12345678;

   logic         clk;
   logic         reset;
   logic         start_valid;
   logic         start_ready;
   logic [255:0] key_in;
   logic         key_len;
   logic         busy;
   logic         keys_valid;
   logic [3:0]   rd_addr;
   logic [127:0] rd_key;
   logic [127:0] gk_key;
   logic [127:0] gk_prev_key;
   logic         gk_keylen;
   logic         gk_flip;
   logic [3:0]   gk_rnum;
   logic         gk_valid_in;
   logic         gk_valid_out;
   logic [127:0] gk_out_key;

   key_sched_ctrl #(.RK_W(128), .NUM_RK(15)) dut (
      .clk(clk), .reset(reset), .start_valid(start_valid), .start_ready(start_ready),
      .key_in(key_in), .key_len(key_len), .busy(busy), .keys_valid(keys_valid),
      .rd_addr(rd_addr), .rd_key(rd_key), .gk_key(gk_key), .gk_prev_key(gk_prev_key),
      .gk_keylen(gk_keylen), .gk_flip(gk_flip), .gk_rnum(gk_rnum),
      .gk_valid_in(gk_valid_in), .gk_valid_out(gk_valid_out), .gk_out_key(gk_out_key)
   );

   typedef struct packed {logic kl; logic fl; logic [3:0] rn;} iss_t;
   typedef struct packed {logic [3:0] a; logic [127:0] k;} rd_t;

   iss_t iss_q[$];
   rd_t  rd_q[$];
   iss_t ie;
   rd_t  re;

   int   n_cmp = 0;
   int   n_bad = 0;
   int   cyc = 0;
   int   iss_total = 0;
   int   pend = 0;
   int   bp_issue_abs = -1;
   logic rd_req;
   logic rd_req_d = 1'b0;

   logic       fl256 [13] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
   logic [3:0] rn256 [13] = '{4'd0, 4'd1, 4'd1, 4'd2, 4'd2, 4'd3, 4'd3, 4'd4, 4'd4, 4'd5, 4'd5, 4'd6, 4'd6};

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   always @(posedge clk) rd_req_d <= rd_req;

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = 8'h00;
      logic [7:0] x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p ^= x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   function automatic logic [7:0] sbox(input logic [7:0] v);
      logic [7:0] inv = 8'h00;
      if (v != 8'h00) begin
         inv = 8'h01;
         for (int i = 0; i < 254; i++) inv = gmul(inv, v);
      end
      return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
             ^ {inv[3:0], inv[7:4]} ^ 8'h63;
   endfunction

   function automatic logic [31:0] sub_word(input logic [31:0] w);
      return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
   endfunction

   function automatic logic [127:0] expand(input logic [127:0] cur, input logic [127:0] prev,
                                           input logic kl, input logic fl, input logic [3:0] rn);
      logic [7:0]   rc = 8'h01;
      logic [31:0]  t;
      logic [127:0] base;
      logic [31:0]  o0, o1, o2, o3;
      for (int i = 0; i < int'(rn); i++) rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
      t    = fl ? (sub_word({cur[23:0], cur[31:24]}) ^ {rc, 24'h0}) : sub_word(cur[31:0]);
      base = kl ? prev : cur;
      o0 = base[127:96] ^ t;
      o1 = base[95:64] ^ o0;
      o2 = base[63:32] ^ o1;
      o3 = base[31:0] ^ o2;
      return {o0, o1, o2, o3};
   endfunction

   // Expansion unit: result one cycle after issue, optionally stretched on one issue
   always @(posedge clk) begin
      if (!reset) begin
         gk_valid_out <= 1'b0;
         gk_out_key   <= '0;
         pend         <= 0;
      end else begin
         gk_valid_out <= 1'b0;
         if (gk_valid_in) begin
            gk_out_key <= expand(gk_key, gk_prev_key, gk_keylen, gk_flip, gk_rnum);
            iss_total  <= iss_total + 1;
            if (iss_total + 1 == bp_issue_abs) pend <= 5;
            else gk_valid_out <= 1'b1;
         end else if (pend != 0) begin
            pend <= pend - 1;
            if (pend == 1) gk_valid_out <= 1'b1;
         end
      end
   end

   task automatic chk(input string name, input logic [131:0] act, input logic [131:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, required %h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (reset && gk_valid_in) begin
         if (iss_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL issue_unexpected: got flip=%0d rnum=%0d, required no issue", gk_flip, gk_rnum);
         end else begin
            ie = iss_q.pop_front();
            chk("issue_trace{keylen,flip,rnum}", {gk_keylen, gk_flip, gk_rnum}, ie);
         end
      end
      if (rd_req_d) begin
         if (rd_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL rd_unexpected: got %h, required no read", rd_key);
         end else begin
            re = rd_q.pop_front();
            chk($sformatf("rd_key[%0d]", re.a), rd_key, re.k);
         end
      end
   end

   task automatic rd(input logic [3:0] a, input logic [127:0] k);
      @(posedge clk); #1;
      rd_addr = a;
      rd_req  = 1'b1;
      rd_q.push_back({a, k});
      @(posedge clk); #1;
      rd_req = 1'b0;
   endtask

   task automatic to_cycle(input int c);
      while (cyc < c) begin
         @(posedge clk); #1;
      end
   endtask

   task automatic start_run(input logic [255:0] k, input logic len, input int acc_rd,
                            input logic [127:0] acc_exp, output int a);
      @(posedge clk); #1;
      chk("ready_before_accept", start_ready, 1'b1);
      start_valid = 1'b1;
      key_in      = k;
      key_len     = len;
      a           = cyc;
      if (acc_rd >= 0) begin
         rd_addr = 4'(acc_rd);
         rd_req  = 1'b1;
         rd_q.push_back({4'(acc_rd), acc_exp});
      end
      if (len) for (int i = 0; i < 13; i++) iss_q.push_back({1'b1, fl256[i], rn256[i]});
      else     for (int i = 0; i < 10; i++) iss_q.push_back({1'b0, 1'b1, 4'(i)});
      @(posedge clk); #1;
      start_valid = 1'b0;
      rd_req      = 1'b0;
      @(negedge clk);
      chk("busy_after_accept", busy, 1'b1);
      chk("keys_valid_after_accept", keys_valid, 1'b0);
   endtask

   task automatic wait_done(input int a, input int lat, input string name);
      for (int i = 0; i < 80; i++) begin
         @(negedge clk);
         if (keys_valid) break;
      end
      chk({name, "_latency"}, 132'(cyc - a), 132'(lat));
      chk({name, "_ready"}, start_ready, 1'b1);
      chk({name, "_busy"}, busy, 1'b0);
      chk({name, "_issues_left"}, 132'(iss_q.size()), 132'd0);
   endtask

   task automatic chk_reset_state(input string p);
      chk({p, "_start_ready"}, start_ready, 1'b1);
      chk({p, "_busy"}, busy, 1'b0);
      chk({p, "_keys_valid"}, keys_valid, 1'b0);
      chk({p, "_gk_valid_in"}, gk_valid_in, 1'b0);
      chk({p, "_gk_data"}, {gk_key, gk_keylen, gk_flip}, '0);
      chk({p, "_gk_prev_rnum"}, {gk_prev_key, gk_rnum}, '0);
      chk({p, "_rd_key"}, rd_key, '0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no end of run, required end before time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int a;
      reset       = 1'b0;
      start_valid = 1'b0;
      key_in      = '0;
      key_len     = 1'b0;
      rd_addr     = '0;
      rd_req      = 1'b0;
      repeat (2) @(negedge clk);
      chk_reset_state("por");
      @(posedge clk); #1;
      reset = 1'b1;

      // FIPS-197 C.1, upper key half must be ignored
      start_run({JUNK, K_C1}, 1'b0, -1, '0, a);
      wait_done(a, 21, "c1");
      rd(4'd0, K_C1);
      rd(4'd1, C1_RK1);
      rd(4'd10, C1_RK10);
      rd(4'd11, '0);

      // FIPS-197 A.1 re-accepted from DONE
      start_run({JUNK, K_A1}, 1'b0, -1, '0, a);
      wait_done(a, 21, "a1");
      rd(4'd1, A1_RK1);
      rd(4'd10, A1_RK10);

      // FIPS-197 C.3 back-to-back from DONE
      start_run(K_C3, 1'b1, -1, '0, a);
      wait_done(a, 27, "c3");
      rd(4'd0, K_C3[255:128]);
      rd(4'd1, C3_RK1);
      rd(4'd2, C3_RK2);
      rd(4'd14, C3_RK14);
      rd(4'd15, '0);

      // accept with a same-cycle read: old rk[14] back, new rk[0] on the next read
      start_run({JUNK, K_A1}, 1'b0, 14, C3_RK14, a);
      rd(4'd0, K_A1);
      wait_done(a, 21, "a1_after_c3");
      rd(4'd11, '0);
      rd(4'd10, A1_RK10);

      // reset in the middle of a C.1 run
      start_run({JUNK, K_C1}, 1'b0, -1, '0, a);
      to_cycle(a + 9);
      reset = 1'b0;
      @(negedge clk);
      chk_reset_state("midrun");
      iss_q.delete();
      @(posedge clk); #1;
      reset = 1'b1;
      rd(4'd10, '0);
      start_run({JUNK, K_C1}, 1'b0, -1, '0, a);
      wait_done(a, 21, "c1_rerun");
      rd(4'd10, C1_RK10);

      // backpressure on round 4 plus a start pulse while busy
      bp_issue_abs = iss_total + 4;
      start_run({JUNK, K_A1}, 1'b0, -1, '0, a);
      to_cycle(a + 5);
      start_valid = 1'b1;
      key_in      = {JUNK, JUNK};
      key_len     = 1'b1;
      to_cycle(a + 7);
      start_valid = 1'b0;
      to_cycle(a + 10);
      @(negedge clk);
      chk("stall_busy", busy, 1'b1);
      chk("stall_no_issue", gk_valid_in, 1'b0);
      chk("stall_hold{flip,rnum}", {gk_flip, gk_rnum}, {1'b1, 4'd3});
      wait_done(a, 26, "a1_bp");
      rd(4'd1, A1_RK1);
      rd(4'd10, A1_RK10);

      repeat (3) @(posedge clk);
      chk("reads_left", 132'(rd_q.size()), 132'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
